// File: rtl/exec_mem_pipe.sv
// EX/MEM pipeline register with a 2-entry skid buffer, synchronous flush and halt tracking.
// Define EXMEM_FWD_EN to add the register-forwarding taps (fwd_valid, fwd_wsel, fwd_data).
module exec_mem_pipe #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int WSRC_W = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid must not depend on ready, and ready here depends on registers only.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_alu_result,
  input  logic [WORD_W-1:0] in_instr_npc,
  input  logic [WORD_W-1:0] in_dmemstore,
  input  logic [REG_W-1:0]  in_wsel,
  input  logic [WSRC_W-1:0] in_wdat_source,
  input  logic              in_halt,
  input  logic              in_dmemREN,
  input  logic              in_dmemWEN,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_alu_result,
  output logic [WORD_W-1:0] out_instr_npc,
  output logic [WORD_W-1:0] out_dmemstore,
  output logic [REG_W-1:0]  out_wsel,
  output logic [WSRC_W-1:0] out_wdat_source,
  output logic              out_halt,
  output logic              out_dmemREN,
  output logic              out_dmemWEN,
  output logic              halted,
`ifdef EXMEM_FWD_EN
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_wsel,
  output logic [WORD_W-1:0] fwd_data,
`endif
  output logic [1:0]        dbg_state
);

  localparam int PW = 3*WORD_W + REG_W + WSRC_W + 3;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t        state;
  logic [PW-1:0] m_q;
  logic [PW-1:0] s_q;
  logic [PW-1:0] in_bundle;
  logic          halt_pend;
  logic          m_v;
  logic          s_v;
  logic          accept;
  logic          pop;

  assign in_bundle = {in_alu_result, in_instr_npc, in_dmemstore, in_wsel,
                      in_wdat_source, in_halt, in_dmemREN, in_dmemWEN};

  assign m_v      = (state != EMPTY);
  assign s_v      = (state == FULL);
  assign in_ready = !s_v && !halt_pend && !halted;
  assign accept   = in_valid && in_ready;
  assign pop      = m_v && out_ready;

  assign {out_alu_result, out_instr_npc, out_dmemstore, out_wsel,
          out_wdat_source, out_halt} = m_q[PW-1:2];
  assign out_valid   = m_v;
  assign out_dmemREN = m_q[1] && m_v;
  assign out_dmemWEN = m_q[0] && m_v;
  assign dbg_state   = state;

`ifdef EXMEM_FWD_EN
  assign fwd_valid = m_v && !m_q[1] && (out_wsel != '0);
  assign fwd_wsel  = out_wsel;
  assign fwd_data  = out_alu_result;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= EMPTY;
      m_q       <= '0;
      s_q       <= '0;
      halt_pend <= 1'b0;
      halted    <= 1'b0;
    end else if (flush) begin
      // Flush wins over any accept or pop this cycle; payload is left as is.
      state     <= EMPTY;
      halt_pend <= 1'b0;
    end else begin
      if (accept && in_halt) halt_pend <= 1'b1;
      if (pop && out_halt) begin
        halted    <= 1'b1;
        halt_pend <= 1'b0;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= ONE;
            m_q   <= in_bundle;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_q <= in_bundle;
          end else if (accept) begin
            state <= FULL;
            s_q   <= in_bundle;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state <= ONE;
            m_q   <= s_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/exec_mem_pipe.md
# exec_mem_pipe

Parametrised EX/MEM pipeline register for the pipelined datapath, carrying the execute-stage result bundle into the memory stage. Generalises the plain EX/MEM latch:
- configurable field widths;
- valid/ready handshake on both sides;
- 2-entry skid buffer, so stalls never create a combinational ready path;
- synchronous flush;
- halt-commit tracking.

Optional register-forwarding taps are compiled in by macro.

## Interface
Parameters:
- WORD_W, 32, width of alu_result, instr_npc, dmemstore
- REG_W, 5, width of wsel
- WSRC_W, 2, width of wdat_source

Ports:
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents a bundle
- in_ready  out  1  block accepts the bundle this cycle
- in_alu_result, in_instr_npc, in_dmemstore  in  WORD_W each  payload
- in_wsel  in  REG_W  payload
- in_wdat_source  in  WSRC_W  payload
- in_halt, in_dmemREN, in_dmemWEN  in  1 each  payload
- flush  in  1  discard all held entries
- out_valid  out  1  memory-stage bundle valid
- out_ready  in  1  memory stage consumes the bundle
- out_alu_result, out_instr_npc, out_dmemstore, out_wsel, out_wdat_source, out_halt  out  as inputs  payload from main entry
- out_dmemREN, out_dmemWEN  out  1  main-entry strobe ANDed with out_valid
- halted  out  1  sticky: a halt bundle has been consumed downstream

## Operation
- Storage:
  - main entry M drives all out_* signals;
  - skid entry S holds one overflow bundle.
- State from (M.v, S.v): EMPTY (0,0), ONE (1,0), FULL (1,1).
- accept = in_valid & in_ready. pop = out_valid & out_ready. out_valid = M.v.
- in_ready = !S.v & !halt_pend & !halted. It is a function of registers only.
- Transitions when flush=0:
  - EMPTY: accept -> ONE, M<=in.
  - ONE: accept&pop -> ONE, M<=in. accept&!pop -> FULL, S<=in. pop&!accept -> EMPTY. Neither -> hold.
  - FULL: pop -> ONE, M<=S, S.v<=0. Otherwise hold. Accept is impossible in FULL.
- flush=1 has priority over accept and pop:
  - next state EMPTY; the input bundle that cycle is dropped;
  - halt_pend<=0; halted is unaffected.
- Halt handling:
  - accepting a bundle with in_halt=1 sets halt_pend;
  - pop of a bundle with halt=1 sets halted and clears halt_pend;
  - halted is cleared only by nRST.
- Payload registers update only on load; held payload is stable while out_valid & !out_ready.
- No arithmetic is performed; all fields pass through at identical width.

## Timing
- Reset (nRST low, asynchronous):
  - M.v=S.v=0, halt_pend=0, halted=0;
  - all payload registers 0;
  - so out_valid=0, out_dmemREN=out_dmemWEN=0, all out_* 0;
  - in_ready=1 from the first edge after release.
- Latency: a bundle accepted at edge k appears on out_* after edge k (visible cycle k+1).
- Throughput: 1 bundle/cycle with out_ready held high.
- After a one-cycle out_ready drop: the second bundle goes to S, and in_ready falls the following cycle.
- Reset mid-operation discards both entries and halt state immediately.
- Flush and reset take effect the same way regardless of state; flush is synchronous.

## Configuration
- EXMEM_FWD_EN defined adds these ports:
  - fwd_valid  out  1  = M.v & !M.dmemREN & (M.wsel != 0);
  - fwd_wsel  out  REG_W  = M.wsel;
  - fwd_data  out  WORD_W  = M.alu_result.
  - All are combinational from M and are 0 in reset.
- EXMEM_FWD_EN undefined: these ports and their logic are absent. The rest of the behaviour is identical.

## Test plan
- Reset, then drive 4 bundles back-to-back (alu_result 1..4) with out_ready=1 -> out_valid from cycle 1; outputs 1,2,3,4 on consecutive cycles; in_ready stays 1.
- out_ready=0 for 3 cycles while in_valid=1 -> bundle A held on outputs, B captured in S, in_ready=0 from the second stall cycle. On out_ready=1: A then B; no loss or duplication.
- Bundle with dmemWEN=1 held while out_valid=0 after a flush -> out_dmemWEN=0; flush in FULL -> out_valid=0 next cycle; the input presented with flush is never output.
- Accept halt bundle -> in_ready=0 next cycle. Pop it -> halted=1 and stays 1 through a later flush until nRST.
- Accept halt bundle, then flush before pop -> halted stays 0 and in_ready returns to 1.
- With EXMEM_FWD_EN: M.wsel=5, dmemREN=0, alu_result=0xDEAD -> fwd_valid=1, fwd_wsel=5, fwd_data=0xDEAD. With wsel=0 or dmemREN=1 -> fwd_valid=0.
